// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 keyboard LED controller.
//   ps2_state_t : controller FSM states
//   CMD_*/RSP_* : keyboard command and reply bytes
//   SC_*        : make scancodes of the three lock keys
//   lock_mask() : maps a scancode to its {caps, num, scroll} LED bit
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    WAIT_ACK1,
    SEND_VAL,
    WAIT_ACK2
  } ps2_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_NUM    = 8'h77;
  localparam logic [7:0] SC_SCROLL = 8'h7E;

  function automatic logic [2:0] lock_mask(input logic [7:0] code);
    case (code)
      SC_CAPS:   return 3'b100;
      SC_NUM:    return 3'b010;
      SC_SCROLL: return 3'b001;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ps2_reply_timer.sv
// ps2_reply_timer -- loadable down-counter that bounds the wait for a
// keyboard reply.
//   clk, rst : clock, asynchronous active-high reset
//   load     : restart the count (takes priority over clr/en)
//   clr      : park the counter at zero
//   en       : count down; only meaningful while waiting for a reply
//   expired  : high in the TIMEOUT_CYC-th enabled cycle after load
module ps2_reply_timer #(
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] cnt;

  // Loaded with TIMEOUT_CYC-1 so that expiry lands on the last cycle of
  // the wait window rather than one cycle after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (load)              cnt <= CW'(TIMEOUT_CYC - 1);
    else if (clr)               cnt <= '0;
    else if (en && cnt != '0)   cnt <= cnt - CW'(1);
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/ps2_led_ctrl.sv
// ps2_led_ctrl -- tracks caps/num/scroll lock state from decoded key
// events and pushes it to the keyboard with the 0xED <value> sequence.
//   clk, rst           : clock, asynchronous active-high reset
//   key_valid          : key event strobe from the decoder
//   last_change[8:0]   : {extend, scancode} of the event
//   key_down[511:0]    : pressed-key vector from the decoder
//   tx_req, tx_byte    : byte transmit request to the PS/2 sender
//   tx_done            : transmit-complete strobe
//   rx_valid, rx_byte  : byte received from the keyboard
//   leds[2:0]          : {caps, num, scroll} lock state
//   busy               : a sequence is in progress
//   err                : one-cycle pulse when a sequence is abandoned
// Build option: define PS2_LED_RETRY_EN to retry on 0xFE/timeout up to
// MAX_RETRY times; otherwise the first 0xFE or timeout abandons.
module ps2_led_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 2000000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  output logic         tx_req,
  output logic [7:0]   tx_byte,
  input  logic         tx_done,
  input  logic         rx_valid,
  input  logic [7:0]   rx_byte,
  output logic [2:0]   leds,
  output logic         busy,
  output logic         err
);

  ps2_state_t state_q, state_d;
  logic       pending_q, pending_d;
  logic       err_d;
  logic [2:0] val_q;
  logic [2:0] lock_bits, leds_d;
  logic       lock_ev;
  logic       retry_req, retry_left;
  ps2_state_t retry_tgt;
  logic       in_wait_q, in_wait_d;
  logic       tmr_expired;

  assign lock_bits = lock_mask(last_change[7:0]);
  assign lock_ev   = key_valid && !last_change[8] && key_down[last_change] && (lock_bits != '0);
  assign leds_d    = lock_ev ? (leds ^ lock_bits) : leds;

  assign in_wait_q = (state_q == WAIT_ACK1) || (state_q == WAIT_ACK2);
  assign in_wait_d = (state_d == WAIT_ACK1) || (state_d == WAIT_ACK2);
  assign busy      = (state_q != IDLE);

  ps2_reply_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (in_wait_d && (state_d != state_q)),
    .clr     (!in_wait_d),
    .en      (in_wait_q),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    err_d     = 1'b0;
    retry_req = 1'b0;
    retry_tgt = SEND_CMD;
    tx_req    = 1'b0;
    tx_byte   = '0;
    case (state_q)
      IDLE: begin
        if (lock_ev || pending_q) begin
          state_d   = SEND_CMD;
          pending_d = 1'b0;
        end
      end
      SEND_CMD: begin
        tx_req  = 1'b1;
        tx_byte = CMD_SET_LEDS;
        if (tx_done) state_d = WAIT_ACK1;
      end
      WAIT_ACK1: begin
        if (rx_valid && rx_byte == RSP_ACK) begin
          state_d = SEND_VAL;
        end else if ((rx_valid && rx_byte == RSP_RESEND) || tmr_expired) begin
          retry_req = 1'b1;
          retry_tgt = SEND_CMD;
        end
      end
      SEND_VAL: begin
        tx_req  = 1'b1;
        tx_byte = {5'b0, val_q};
        if (tx_done) state_d = WAIT_ACK2;
      end
      WAIT_ACK2: begin
        if (rx_valid && rx_byte == RSP_ACK) begin
          state_d = IDLE;
        end else if (rx_valid && rx_byte == RSP_RESEND) begin
          retry_req = 1'b1;
          retry_tgt = SEND_VAL;
        end else if (tmr_expired) begin
          retry_req = 1'b1;
          retry_tgt = SEND_CMD;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && lock_ev) pending_d = 1'b1;

    // Without the retry option retry_left is tied low, so every retry
    // request falls through to the abandon path.
    if (retry_req) begin
      if (retry_left) begin
        state_d = retry_tgt;
      end else begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end
  end

`ifdef PS2_LED_RETRY_EN
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    retry_q <= '0;
    else if (state_q == IDLE && state_d != IDLE) retry_q <= '0;
    else if (retry_req && retry_left)           retry_q <= retry_q + RW'(1);
  end

  assign retry_left = (retry_q != RW'(MAX_RETRY));
`else
  assign retry_left = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      err       <= 1'b0;
      leds      <= '0;
      val_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      err       <= err_d;
      leds      <= leds_d;
      // Capture the LED state that is current on the first SEND_VAL cycle,
      // including a toggle landing on the same edge.
      if (state_d == SEND_VAL && state_q != SEND_VAL) val_q <= leds_d;
    end
  end

endmodule

// File: tb/tb_ps2_led_ctrl.sv
module tb_ps2_led_ctrl;

  localparam int unsigned TMO  = 100;
  localparam int unsigned MAXR = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic [8:0]   last_change = '0;
  logic [511:0] key_down = '0;
  logic         tx_req;
  logic [7:0]   tx_byte;
  logic         tx_done = 1'b0;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_byte = '0;
  logic [2:0]   leds;
  logic         busy;
  logic         err;

  int unsigned n_cmp   = 0;
  int unsigned n_bad   = 0;
  int unsigned err_cnt = 0;
  logic [2:0]  leds_m  = '0;

  ps2_led_ctrl #(.TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .last_change (last_change),
    .key_down    (key_down),
    .tx_req      (tx_req),
    .tx_byte     (tx_byte),
    .tx_done     (tx_done),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .leds        (leds),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err === 1'b1) err_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Lock-key rule: make (not extended, key held) of caps/num/scroll.
  function automatic logic [2:0] model_mask(input logic [8:0] lc, input bit down);
    if (lc[8] || !down) return 3'b000;
    if (lc[7:0] == 8'h58) return 3'b100;
    if (lc[7:0] == 8'h77) return 3'b010;
    if (lc[7:0] == 8'h7E) return 3'b001;
    return 3'b000;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    leds_m = '0;
    chk("rst_leds",   32'(leds),    32'(0));
    chk("rst_txreq",  32'(tx_req),  32'(0));
    chk("rst_txbyte", 32'(tx_byte), 32'(0));
    chk("rst_busy",   32'(busy),    32'(0));
    chk("rst_err",    32'(err),     32'(0));
  endtask

  task automatic key_event(input logic [8:0] lc, input bit down, input string tag);
    last_change = lc;
    key_down = '0;
    if (down) key_down[lc] = 1'b1;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    key_down = '0;
    leds_m = leds_m ^ model_mask(lc, down);
    chk(tag, 32'(leds), 32'(leds_m));
  endtask

  task automatic wait_tx(input logic [7:0] exp, input string tag);
    int unsigned n = 0;
    while (tx_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (tx_req !== 1'b1) begin
      chk({tag, "_req"}, 32'(tx_req), 32'(1));
      return;
    end
    chk(tag, 32'(tx_byte), 32'(exp));
    repeat ($urandom_range(0, 3)) tick();
    chk({tag, "_hold"}, 32'({tx_req, tx_byte}), 32'({1'b1, exp}));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk({tag, "_rel"}, 32'(tx_req), 32'(0));
  endtask

  task automatic reply(input logic [7:0] b);
    repeat ($urandom_range(0, 4)) tick();
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    int unsigned e0;
    int unsigned n_ed;
    int unsigned k;
    bit          seen;
    bit          got_err;
    logic [8:0]  lc;
    bit          down;
    int unsigned r;

    tick();
    do_reset();

    // Caps make, two ACKs.
    e0 = err_cnt;
    key_event(9'h058, 1'b1, "caps_leds");
    chk("caps_busy", 32'(busy), 32'(1));
    wait_tx(8'hED, "caps_cmd");
    reply(8'hFA);
    wait_tx(8'h04, "caps_val");
    reply(8'hFA);
    chk("caps_idle", 32'(busy), 32'(0));
    tick();
    chk("caps_noerr", err_cnt, e0);
    chk("caps_final", 32'(leds), 32'(3'b100));

    // Num make, resend after 0xED.
    do_reset();
    e0 = err_cnt;
    key_event(9'h077, 1'b1, "num_leds");
    wait_tx(8'hED, "num_cmd");
    reply(8'hFE);
`ifdef PS2_LED_RETRY_EN
    wait_tx(8'hED, "num_cmd_re");
    reply(8'hFA);
    wait_tx(8'h02, "num_val");
    reply(8'hFA);
    chk("num_idle", 32'(busy), 32'(0));
    tick();
    chk("num_noerr", err_cnt, e0);
`else
    chk("num_abort", 32'(busy), 32'(0));
    tick();
    chk("num_err", err_cnt, e0 + 1);
`endif

    // No reply at all: timeouts.
    do_reset();
    e0 = err_cnt;
    n_ed = 0;
    got_err = 1'b0;
    key_event(9'h058, 1'b1, "tmo_leds");
    for (int a = 0; a < 8 && !got_err; a++) begin
      wait_tx(8'hED, "tmo_cmd");
      n_ed++;
      k = 0;
      while (tx_req !== 1'b1 && err !== 1'b1 && k < 150) begin
        tick();
        k++;
      end
      chk("tmo_cycles", k, TMO);
      if (err === 1'b1) got_err = 1'b1;
      if (k >= 150) break;
    end
    tick();
`ifdef PS2_LED_RETRY_EN
    chk("tmo_sends", n_ed, MAXR + 1);
`else
    chk("tmo_sends", n_ed, 1);
`endif
    chk("tmo_errcnt", err_cnt, e0 + 1);
    chk("tmo_idle", 32'(busy), 32'(0));

    // Scroll make while waiting for the first ACK of a caps sequence.
    do_reset();
    e0 = err_cnt;
    key_event(9'h058, 1'b1, "pend_caps");
    wait_tx(8'hED, "pend_cmd1");
    key_event(9'h07E, 1'b1, "pend_scroll");
    chk("pend_leds", 32'(leds), 32'(3'b101));
    reply(8'hFA);
    wait_tx(8'h05, "pend_val1");
    reply(8'hFA);
    wait_tx(8'hED, "pend_cmd2");
    reply(8'hFA);
    wait_tx(8'h05, "pend_val2");
    reply(8'hFA);
    chk("pend_idle", 32'(busy), 32'(0));
    tick();
    chk("pend_noerr", err_cnt, e0);

    // Non-lock events: extended caps, caps break, ordinary key.
    do_reset();
    key_event(9'h158, 1'b1, "ext_leds");
    key_event(9'h058, 1'b0, "brk_leds");
    key_event(9'h01C, 1'b1, "oth_leds");
    seen = 1'b0;
    repeat (5) begin
      if (tx_req !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("nonlock_quiet", 32'(seen), 32'(0));

    // Reset during SEND_VAL.
    do_reset();
    key_event(9'h077, 1'b1, "rstv_leds");
    wait_tx(8'hED, "rstv_cmd");
    reply(8'hFA);
    k = 0;
    while (tx_req !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("rstv_inval", 32'(tx_byte), 32'(8'h02));
    rst = 1'b1;
    #1;
    chk("rstv_txreq", 32'(tx_req), 32'(0));
    chk("rstv_leds",  32'(leds),   32'(0));
    chk("rstv_busy",  32'(busy),   32'(0));
    tick();
    rst = 1'b0;
    leds_m = '0;
    reply(8'hFA);
    seen = 1'b0;
    repeat (5) begin
      if (tx_req !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("rstv_quiet", 32'(seen), 32'(0));

    // Randomized events against the reference model.
    do_reset();
    e0 = err_cnt;
    for (int it = 0; it < 24; it++) begin
      r = $urandom_range(0, 5);
      case (r)
        0:       lc = 9'h058;
        1:       lc = 9'h077;
        2:       lc = 9'h07E;
        default: lc = 9'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 3) == 0) lc[8] = 1'b1;
      down = ($urandom_range(0, 4) != 0);
      key_event(lc, down, "rnd_leds");
      if (model_mask(lc, down) != 3'b000) begin
        wait_tx(8'hED, "rnd_cmd");
`ifdef PS2_LED_RETRY_EN
        if ($urandom_range(0, 2) == 0) begin
          reply(8'hFE);
          wait_tx(8'hED, "rnd_cmd_re");
        end
`endif
        if ($urandom_range(0, 2) == 0) reply(8'($urandom_range(0, 249)));
        reply(8'hFA);
        wait_tx({5'b0, leds_m}, "rnd_val");
`ifdef PS2_LED_RETRY_EN
        if ($urandom_range(0, 2) == 0) begin
          reply(8'hFE);
          wait_tx({5'b0, leds_m}, "rnd_val_re");
        end
`endif
        reply(8'hFA);
        chk("rnd_idle", 32'(busy), 32'(0));
      end else begin
        seen = 1'b0;
        repeat (3) begin
          if (tx_req !== 1'b0 || busy !== 1'b0) seen = 1'b1;
          tick();
        end
        chk("rnd_quiet", 32'(seen), 32'(0));
      end
    end
    tick();
    chk("rnd_noerr", err_cnt, e0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
